// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode-stage pipeline controller.
// Latency: n/a (types, constants and a pure decode helper only).
// Backpressure: n/a.
package pipeline_pkg;

  // Interrupt service entry used when the top is not overridden
  localparam logic [7:0] VECTOR_ADDR_DEF = 8'hF0;

  // Opcode points that are not whole ranges (R-type is 0x00-0x0F, I-type 0x10-0x1F)
  localparam logic [5:0] OP_LW   = 6'h20;
  localparam logic [5:0] OP_RETI = 6'h3E;
  localparam logic [5:0] OP_NOP  = 6'h3F;

  // Operand source selects driven onto mux_sel_A / mux_sel_B
  localparam logic [1:0] SEL_RF = 2'b00;
  localparam logic [1:0] SEL_EX = 2'b01;
  localparam logic [1:0] SEL_DM = 2'b10;
  localparam logic [1:0] SEL_WB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'd0,
    CLS_I    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_RETI = 3'd3,
    CLS_NOP  = 3'd4
  } op_class_t;

  // One stage of the shadow pipe that mirrors EX, DM and WB
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       we;
    logic       is_load;
  } shadow_t;

  // Classify an opcode; every undefined opcode behaves as a NOP
  function automatic op_class_t op_class(input logic [5:0] op);
    op_class_t cls;
    if (op[5:4] == 2'b00)    cls = CLS_R;
    else if (op[5:4] == 2'b01) cls = CLS_I;
    else if (op == OP_LW)    cls = CLS_LW;
    else if (op == OP_RETI)  cls = CLS_RETI;
    else                     cls = CLS_NOP;
    return cls;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd.sv
// Hazard compare of one decode source register against the EX/DM/WB shadow pipe.
// Latency: purely combinational.
// Backpressure: none; load_hit tells the controller to hold decode for one cycle.
module fwd_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] src,
  input  logic       use_src,
  input  shadow_t    ex,
  input  shadow_t    dm,
  input  shadow_t    wb,
  output logic [1:0] sel,
  output logic       load_hit
);

  logic need;
  logic hit_ex;
  logic hit_dm;
  logic hit_wb;
  logic unused_load_bits;

  // r0 is hard-wired zero, so it is never a forwarding target
  assign need   = use_src && (src != 5'd0);
  assign hit_ex = need && ex.valid && ex.we && (ex.rd == src);
  assign hit_dm = need && dm.valid && dm.we && (dm.rd == src);
  assign hit_wb = need && wb.valid && wb.we && (wb.rd == src);

  // A load still in EX has no result yet; only that case needs a stall
  assign load_hit = hit_ex && ex.is_load;

  assign unused_load_bits = dm.is_load ^ wb.is_load;

  // Youngest producer wins
  always_comb begin
    sel = SEL_RF;
    if (hit_ex)      sel = SEL_EX;
    else if (hit_dm) sel = SEL_DM;
    else if (hit_wb) sel = SEL_WB;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-stage controller: operand forwarding, load-use stall, interrupt entry and RETI.
// Latency: all control outputs combinational from state and ins; state advances each edge.
// Backpressure: stall holds PC/decode, bubble injects a NOP into EX; no upstream handshake.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter logic [7:0] VECTOR_ADDR  = VECTOR_ADDR_DEF,
  parameter int         DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] ins,
  input  logic        ins_valid,
  input  logic [7:0]  Current_Address,
  input  logic        interrupt,
  output logic [1:0]  mux_sel_A,
  output logic [1:0]  mux_sel_B,
  output logic        imm_sel,
  output logic        stall,
  output logic        bubble,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic        int_ack,
  output logic [7:0]  epc
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  // Decode fields
  logic [5:0] opcode;
  logic [4:0] rd;
  logic [4:0] rs;
  logic [4:0] rt;
  op_class_t  cls;
  logic       reads_rs;
  logic       reads_rt;
  logic       is_load;
  logic       unused_imm_low;

  assign opcode   = ins[23:18];
  assign rd       = ins[17:13];
  assign rs       = ins[12:8];
  assign rt       = ins[7:3];
  assign cls      = op_class(opcode);
  assign reads_rs = (cls == CLS_R) || (cls == CLS_I) || (cls == CLS_LW);
  assign reads_rt = (cls == CLS_R);
  assign is_load  = (cls == CLS_LW);
  // imm8 low bits feed the datapath only; the controller never looks at them
  assign unused_imm_low = ^ins[2:0];

  // State
  state_t     state;
  state_t     state_nxt;
  logic [7:0] drain_cnt;
  logic [7:0] drain_cnt_nxt;
  logic       in_isr;
  logic       in_isr_nxt;
  logic [7:0] epc_nxt;
  // Low from reset until the first edge afterwards; keeps every output quiet in that window
  logic       run;
  shadow_t    ex_ent;
  shadow_t    dm_ent;
  shadow_t    wb_ent;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       load_hit_a;
  logic       load_hit_b;
  logic       issue;

  fwd_unit u_fwd_a (
    .src      (rs),
    .use_src  (reads_rs),
    .ex       (ex_ent),
    .dm       (dm_ent),
    .wb       (wb_ent),
    .sel      (sel_a),
    .load_hit (load_hit_a)
  );

  fwd_unit u_fwd_b (
    .src      (rt),
    .use_src  (reads_rt),
    .ex       (ex_ent),
    .dm       (dm_ent),
    .wb       (wb_ent),
    .sel      (sel_b),
    .load_hit (load_hit_b)
  );

  // I-type and LW never read rt, so mux_sel_B is already 00 whenever imm_sel is set
  assign mux_sel_A = run ? sel_a : SEL_RF;
  assign mux_sel_B = run ? sel_b : SEL_RF;
  assign imm_sel   = run && ((cls == CLS_I) || (cls == CLS_LW));

  assign issue = run && ins_valid && !stall && !bubble;

  // Interrupt FSM, RETI and load-use: next state and control outputs
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    in_isr_nxt    = in_isr;
    epc_nxt       = epc;
    stall         = 1'b0;
    bubble        = 1'b0;
    pc_load       = 1'b0;
    pc_target     = 8'h00;
    int_ack       = 1'b0;
    if (run) begin
      case (state)
        ST_IDLE: begin
          // Interrupt takes priority over a simultaneous load-use hazard
          if (interrupt && !in_isr) begin
            state_nxt     = ST_DRAIN;
            drain_cnt_nxt = 8'd0;
            epc_nxt       = Current_Address;
            stall         = 1'b1;
            bubble        = 1'b1;
          end else if (ins_valid && (cls == CLS_RETI) && in_isr) begin
            pc_load    = 1'b1;
            pc_target  = epc;
            bubble     = 1'b1;
            in_isr_nxt = 1'b0;
          end else if (ins_valid && (load_hit_a || load_hit_b)) begin
            stall  = 1'b1;
            bubble = 1'b1;
          end
        end
        ST_DRAIN: begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt = ST_VECTOR;
          end else begin
            drain_cnt_nxt = drain_cnt + 8'd1;
          end
        end
        ST_VECTOR: begin
          stall         = 1'b1;
          bubble        = 1'b1;
          pc_load       = 1'b1;
          pc_target     = VECTOR_ADDR;
          int_ack       = 1'b1;
          in_isr_nxt    = 1'b1;
          drain_cnt_nxt = 8'd0;
          state_nxt     = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      drain_cnt <= 8'd0;
      in_isr    <= 1'b0;
      epc       <= 8'h00;
      run       <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      in_isr    <= in_isr_nxt;
      epc       <= epc_nxt;
      run       <= 1'b1;
    end
  end

  // Shadow pipe: EX takes the issued instruction or a bubble, then shifts to DM and WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ent <= '0;
      dm_ent <= '0;
      wb_ent <= '0;
    end else begin
      if (issue) begin
        ex_ent.valid   <= 1'b1;
        ex_ent.rd      <= rd;
        ex_ent.we      <= reads_rs && (rd != 5'd0);
        ex_ent.is_load <= is_load;
      end else begin
        ex_ent <= '0;
      end
      dm_ent <= ex_ent;
      wb_ent <= dm_ent;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed interrupt/reset sequences,
// and randomized traffic compared against an instruction-history reference model.
module tb_pipeline_ctrl;

  localparam int         DRAIN = 3;
  localparam logic [7:0] VEC   = 8'hF0;

  localparam logic [5:0] ADD  = 6'h01;
  localparam logic [5:0] ADDI = 6'h10;
  localparam logic [5:0] LW   = 6'h20;
  localparam logic [5:0] RETI = 6'h3E;
  localparam logic [5:0] NOP  = 6'h3F;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] ins;
  logic        ins_valid;
  logic [7:0]  Current_Address;
  logic        interrupt;
  logic [1:0]  mux_sel_A;
  logic [1:0]  mux_sel_B;
  logic        imm_sel;
  logic        stall;
  logic        bubble;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        int_ack;
  logic [7:0]  epc;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.VECTOR_ADDR(VEC), .DRAIN_CYCLES(DRAIN)) dut (
    .clk             (clk),
    .reset           (reset),
    .ins             (ins),
    .ins_valid       (ins_valid),
    .Current_Address (Current_Address),
    .interrupt       (interrupt),
    .mux_sel_A       (mux_sel_A),
    .mux_sel_B       (mux_sel_B),
    .imm_sel         (imm_sel),
    .stall           (stall),
    .bubble          (bubble),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .int_ack         (int_ack),
    .epc             (epc)
  );

  function automatic logic [23:0] mk(input logic [5:0] op, input logic [4:0] d,
                                     input logic [4:0] s, input logic [4:0] t);
    return {op, d, s, t, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [23:0] i, input logic v, input logic irq, input logic [7:0] pc);
    ins = i; ins_valid = v; interrupt = irq; Current_Address = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle, then check the stall/PC/interrupt group
  task automatic look(input string name, input logic st, input logic bu, input logic pl,
                      input logic [7:0] pt, input logic ack);
    #2;
    chk({name, "_stall"},  8'(stall),   8'(st));
    chk({name, "_bubble"}, 8'(bubble),  8'(bu));
    chk({name, "_pcload"}, 8'(pc_load), 8'(pl));
    chk({name, "_pctgt"},  pc_target,   pt);
    chk({name, "_ack"},    8'(int_ack), 8'(ack));
  endtask

  task automatic zero_all(input string name);
    chk({name, "_selA"}, 8'(mux_sel_A), 8'd0);
    chk({name, "_selB"}, 8'(mux_sel_B), 8'd0);
    chk({name, "_imm"},  8'(imm_sel),   8'd0);
    chk({name, "_epc"},  epc,           8'h00);
    look(name, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Reset, release while clk is low, then one idle edge so the controller is running
  task automatic do_reset();
    drive(24'h0, 1'b0, 1'b0, 8'h00);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step();
  endtask

  typedef struct {
    logic [23:0] i;
    logic        v;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        imm;
    logic        st;
  } vec_t;

  vec_t tbl[16];

  // Reference model: what was issued 1, 2, 3 cycles ago, and where the interrupt sequence is
  int         hist_rd[3];
  bit         hist_ld[3];
  int         since_acc;
  bit         m_isr;
  logic [7:0] m_epc;

  function automatic int fwd_ref(input bit used, input logic [4:0] src);
    int r = 0;
    if (used && src != 5'd0) begin
      for (int k = 2; k >= 0; k--) if (hist_rd[k] == int'(src)) r = k + 1;
    end
    return r;
  endfunction

  initial begin
    reset = 1'b0;
    // Outputs during reset, with inputs that would otherwise provoke activity
    drive(mk(ADDI, 5'd1, 5'd2, 5'd0), 1'b1, 1'b1, 8'h33);
    #2;
    zero_all("in_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Each row is one cycle; row 0 sits between reset release and the first edge
    tbl[0]  = '{mk(ADDI, 5'd1, 5'd2, 5'd0), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{mk(ADD,  5'd3, 5'd1, 5'd2), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{mk(NOP,  5'd0, 5'd0, 5'd0), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{mk(NOP,  5'd0, 5'd0, 5'd0), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{mk(ADD,  5'd5, 5'd3, 5'd1), 1'b1, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[5]  = '{mk(ADD,  5'd4, 5'd5, 5'd5), 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{mk(ADDI, 5'd6, 5'd5, 5'd4), 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[7]  = '{mk(ADD,  5'd7, 5'd5, 5'd4), 1'b1, 2'b11, 2'b10, 1'b0, 1'b0};
    tbl[8]  = '{mk(LW,   5'd2, 5'd7, 5'd0), 1'b1, 2'b01, 2'b00, 1'b1, 1'b0};
    tbl[9]  = '{mk(ADD,  5'd6, 5'd2, 5'd0), 1'b1, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{mk(ADD,  5'd6, 5'd2, 5'd0), 1'b1, 2'b10, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{mk(ADD,  5'd0, 5'd6, 5'd6), 1'b1, 2'b01, 2'b01, 1'b0, 1'b0};
    tbl[12] = '{mk(ADD,  5'd1, 5'd0, 5'd0), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{mk(RETI, 5'd0, 5'd0, 5'd0), 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{mk(LW,   5'd9, 5'd1, 5'd0), 1'b1, 2'b10, 2'b00, 1'b1, 1'b0};
    tbl[15] = '{mk(ADD,  5'd10, 5'd1, 5'd9), 1'b0, 2'b11, 2'b01, 1'b0, 1'b0};

    for (int r = 0; r < 16; r++) begin
      string nm;
      nm = $sformatf("row%0d", r);
      drive(tbl[r].i, tbl[r].v, 1'b0, 8'(r));
      look(nm, tbl[r].st, tbl[r].st, 1'b0, 8'h00, 1'b0);
      chk({nm, "_selA"}, 8'(mux_sel_A), 8'(tbl[r].a));
      chk({nm, "_selB"}, 8'(mux_sel_B), 8'(tbl[r].b));
      chk({nm, "_imm"},  8'(imm_sel),   8'(tbl[r].imm));
      step();
    end

    // Interrupt entry, drain, vector, held request inside the ISR, RETI
    do_reset();
    drive(mk(ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 8'h24);
    look("irq_accept", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    chk("epc_latched", epc, 8'h24);
    for (int d = 0; d < DRAIN; d++) begin
      drive(mk(NOP, 5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 8'h25);
      look($sformatf("drain%0d", d), 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      step();
    end
    look("vector", 1'b1, 1'b1, 1'b1, VEC, 1'b1);
    step();
    for (int k = 0; k < 6; k++) begin
      drive(mk(NOP, 5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 8'hF1 + 8'(k));
      look($sformatf("isr_hold%0d", k), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
    end
    chk("epc_kept", epc, 8'h24);
    drive(mk(RETI, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 8'hF8);
    look("reti", 1'b0, 1'b1, 1'b1, 8'h24, 1'b0);
    step();
    drive(mk(NOP, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 8'h24);
    look("after_reti", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    step();

    // Second interrupt is accepted again, then reset aborts it mid-drain
    drive(mk(ADD, 5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 8'h55);
    look("irq2_accept", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step();
    drive(mk(ADDI, 5'd3, 5'd1, 5'd0), 1'b1, 1'b0, 8'h56);
    look("irq2_drain", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    zero_all("rst_drain");
    for (int k = 0; k < 2; k++) begin
      step();
      zero_all($sformatf("rst_hold%0d", k));
    end
    @(negedge clk) reset = 1'b1;
    drive(mk(NOP, 5'd0, 5'd0, 5'd0), 1'b1, 1'b0, 8'h00);
    step();
    for (int k = 0; k < DRAIN + 2; k++) begin
      look($sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
    end

    // Randomized traffic against the reference model
    do_reset();
    hist_rd   = '{-1, -1, -1};
    hist_ld   = '{0, 0, 0};
    since_acc = 0;
    m_isr     = 1'b0;
    m_epc     = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      int         sel;
      logic [5:0] op;
      int         iop;
      bit         is_r, is_i, is_lw, is_reti, wr;
      int         e_a, e_b, e_pt;
      bit         e_imm, e_st, e_bu, e_pl, e_ack, accept, reti_eff, iss;
      logic [4:0] f_rd, f_rs, f_rt;

      sel = $urandom_range(0, 9);
      if (sel <= 2)      op = 6'($urandom_range(0, 15));
      else if (sel <= 4) op = 6'($urandom_range(16, 31));
      else if (sel <= 6) op = LW;
      else if (sel == 7) op = RETI;
      else if (sel == 8) op = NOP;
      else               op = 6'($urandom_range(33, 61));
      f_rd = 5'($urandom_range(0, 7));
      f_rs = 5'($urandom_range(0, 7));
      f_rt = 5'($urandom_range(0, 7));
      drive({op, f_rd, f_rs, f_rt, 3'($urandom_range(0, 7))},
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 4), 8'($urandom));
      #2;

      iop     = int'(op);
      is_r    = iop < 16;
      is_i    = iop >= 16 && iop < 32;
      is_lw   = iop == 32;
      is_reti = iop == 62;
      wr      = is_r || is_i || is_lw;
      e_a     = fwd_ref(wr, f_rs);
      e_b     = fwd_ref(is_r, f_rt);
      e_imm   = is_i || is_lw;
      e_st = 0; e_bu = 0; e_pl = 0; e_pt = 0; e_ack = 0; accept = 0; reti_eff = 0;
      if (since_acc >= 1 && since_acc <= DRAIN) begin
        e_st = 1; e_bu = 1;
      end else if (since_acc == DRAIN + 1) begin
        e_st = 1; e_bu = 1; e_pl = 1; e_pt = int'(VEC); e_ack = 1;
      end else if (interrupt && !m_isr) begin
        e_st = 1; e_bu = 1; accept = 1;
      end else if (ins_valid && is_reti && m_isr) begin
        e_pl = 1; e_pt = int'(m_epc); e_bu = 1; reti_eff = 1;
      end else if (ins_valid && hist_ld[0] &&
                   ((wr && f_rs != 0 && hist_rd[0] == int'(f_rs)) ||
                    (is_r && f_rt != 0 && hist_rd[0] == int'(f_rt)))) begin
        e_st = 1; e_bu = 1;
      end

      chk("rnd_selA",   8'(mux_sel_A), 8'(e_a));
      chk("rnd_selB",   8'(mux_sel_B), 8'(e_b));
      chk("rnd_imm",    8'(imm_sel),   8'(e_imm));
      chk("rnd_stall",  8'(stall),     8'(e_st));
      chk("rnd_bubble", 8'(bubble),    8'(e_bu));
      chk("rnd_pcload", 8'(pc_load),   8'(e_pl));
      chk("rnd_pctgt",  pc_target,     8'(e_pt));
      chk("rnd_ack",    8'(int_ack),   8'(e_ack));
      chk("rnd_epc",    epc,           m_epc);

      @(posedge clk);
      iss        = ins_valid && !e_st && !e_bu;
      hist_rd[2] = hist_rd[1];
      hist_ld[2] = hist_ld[1];
      hist_rd[1] = hist_rd[0];
      hist_ld[1] = hist_ld[0];
      hist_rd[0] = (iss && wr && f_rd != 0) ? int'(f_rd) : -1;
      hist_ld[0] = iss && is_lw;
      if (accept) begin
        since_acc = 1;
        m_epc     = Current_Address;
      end else if (since_acc == DRAIN + 1) begin
        since_acc = 0;
        m_isr     = 1'b1;
      end else if (since_acc > 0) begin
        since_acc++;
      end
      if (reti_eff) m_isr = 1'b0;
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
